// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard
// Issue-side hazard scoreboard for the two-pipe core (slot 1 = ALU,
// slot 2 = load/store/branch). Tracks destinations and the N flag that are
// issued but not yet reachable by forwarding. Each cycle it decides whether
// the ID pair issues whole, issues split (slot 1 only), or stalls.
//
// Handshake: issue1/issue2 are same-cycle acceptances of the ID slots. A slot
// is consumed only on a cycle where it is valid and its issue bit is high.
// While stall is high, ID/IF hold. After a split, upstream invalidates slot 1
// and re-presents slot 2.
//
// Optional feature macro: SCOREBOARD_STATS_EN adds the stall_cycles and
// split_cycles saturating event counters.
module dual_issue_scoreboard #(
    parameter int NREG    = 8,
    parameter int AW      = 3,
    parameter int ALU_LAT = 0,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            id_valid1,
    input  logic            id_we1,
    input  logic [AW-1:0]   id_rd1,
    input  logic [AW-1:0]   id_rm1,
    input  logic [AW-1:0]   id_rn1,
    input  logic            id_use_rn1,
    input  logic            id_flag_we1,
    input  logic            id_valid2,
    input  logic            id_we2,
    input  logic [AW-1:0]   id_rd2,
    input  logic            id_st2,
    input  logic [AW-1:0]   id_rm2,
    input  logic [AW-1:0]   id_rn2,
    input  logic            id_flag_use2,
    output logic            issue1,
    output logic            issue2,
    output logic            stall,
    output logic [NREG-1:0] pend_vec
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0]     stall_cycles,
    output logic [15:0]     split_cycles
`endif
);

    localparam logic [1:0] ALU_LD = 2'(ALU_LAT);
    localparam logic [1:0] MEM_LD = 2'(MEM_LAT);

    // Pending counters; r0 has no entry because it is never tracked.
    logic [1:0] cnt_q [1:NREG-1];
    logic [1:0] cnt_d [1:NREG-1];
    logic [1:0] fcnt_q;
    logic [1:0] fcnt_d;

    logic blocked1;
    logic blocked2;
    logic raw12;
    logic waw12;
    logic flag12;
    logic wr1;
    logic wr2;

    // True when register a still has an unforwardable producer in flight.
    function automatic logic src_busy(input logic [AW-1:0] a,
                                      input logic [NREG-1:0] pv);
        if (32'(a) >= NREG) begin
            return 1'b0;
        end
        return pv[a];
    endfunction

    // Pending vector straight from the counters; bit 0 is tied low.
    always_comb begin
        pend_vec    = '0;
        for (int i = 1; i < NREG; i++) begin
            pend_vec[i] = (cnt_q[i] != 2'd0);
        end
    end

    // Hazard detection and issue decision, forced idle by reset and flush.
    always_comb begin
        wr1      = id_we1 && (id_rd1 != '0);
        wr2      = id_we2 && (id_rd2 != '0);

        blocked1 = src_busy(id_rm1, pend_vec) ||
                   (id_use_rn1 && src_busy(id_rn1, pend_vec));

        raw12    = wr1 && ((id_rm2 == id_rd1) || (id_rn2 == id_rd1) ||
                           (id_st2 && (id_rd2 == id_rd1)));
        waw12    = wr1 && wr2 && (id_rd2 == id_rd1);
        flag12   = id_flag_use2 && id_flag_we1;

        issue1   = id_valid1 && !blocked1;

        blocked2 = src_busy(id_rm2, pend_vec) ||
                   src_busy(id_rn2, pend_vec) ||
                   (id_st2 && src_busy(id_rd2, pend_vec)) ||
                   (id_flag_use2 && (fcnt_q != 2'd0)) ||
                   (id_valid1 && issue1 && (raw12 || waw12 || flag12));

        issue2   = id_valid2 && !blocked2 && (issue1 || !id_valid1);
        stall    = (id_valid1 && !issue1) || (id_valid2 && !issue2);

        if (reset || flush) begin
            issue1 = 1'b0;
            issue2 = 1'b0;
            stall  = 1'b0;
        end
    end

    // Next counter values: decrement everything, then load issued writes.
    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            cnt_d[i] = (cnt_q[i] != 2'd0) ? cnt_q[i] - 2'd1 : 2'd0;
        end
        fcnt_d = (fcnt_q != 2'd0) ? fcnt_q - 2'd1 : 2'd0;

        for (int i = 1; i < NREG; i++) begin
            if (issue1 && wr1 && (32'(id_rd1) == i)) begin
                cnt_d[i] = ALU_LD;
            end
            if (issue2 && wr2 && (32'(id_rd2) == i)) begin
                cnt_d[i] = MEM_LD;
            end
        end
        if (issue1 && id_flag_we1) begin
            fcnt_d = ALU_LD;
        end

        if (flush) begin
            for (int i = 1; i < NREG; i++) begin
                cnt_d[i] = 2'd0;
            end
            fcnt_d = 2'd0;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                cnt_q[i] <= 2'd0;
            end
            fcnt_q <= 2'd0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            fcnt_q <= fcnt_d;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] stall_cycles_d;
    logic [15:0] split_cycles_q;
    logic [15:0] split_cycles_d;

    // Saturating event counters; flush does not clear them.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        split_cycles_d = split_cycles_q;
        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (issue1 && id_valid2 && !issue2 && (split_cycles_q != 16'hFFFF)) begin
            split_cycles_d = split_cycles_q + 16'd1;
        end
    end

    // Statistics registers, cleared by reset only.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 16'd0;
            split_cycles_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            split_cycles_q <= split_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign split_cycles = split_cycles_q;
`endif

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Testbench for dual_issue_scoreboard: directed vectors, expected responses
// queued by the driver and compared by an independent monitor each cycle.
// Two instances share the inputs: dut (ALU_LAT=0, MEM_LAT=1) and dut_f
// (ALU_LAT=2, MEM_LAT=1) for the flag / long ALU latency cases.
module tb_dual_issue_scoreboard;

  localparam int W = 12; // {sel, issue1, issue2, stall, pend_vec[7:0]}

  logic clk = 1'b0;
  logic reset, flush;
  logic id_valid1, id_we1, id_use_rn1, id_flag_we1;
  logic [2:0] id_rd1, id_rm1, id_rn1;
  logic id_valid2, id_we2, id_st2, id_flag_use2;
  logic [2:0] id_rd2, id_rm2, id_rn2;

  logic issue1_a, issue2_a, stall_a;
  logic [7:0] pend_a;
  logic issue1_b, issue2_b, stall_b;
  logic [7:0] pend_b;
`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_cycles_a, split_cycles_a, stall_cycles_b, split_cycles_b;
`endif

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc_no = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, actual=running required=finished");
    $fatal(1, "timeout");
  end

  dual_issue_scoreboard #(.NREG(8), .AW(3), .ALU_LAT(0), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_valid1(id_valid1), .id_we1(id_we1), .id_rd1(id_rd1), .id_rm1(id_rm1),
    .id_rn1(id_rn1), .id_use_rn1(id_use_rn1), .id_flag_we1(id_flag_we1),
    .id_valid2(id_valid2), .id_we2(id_we2), .id_rd2(id_rd2), .id_st2(id_st2),
    .id_rm2(id_rm2), .id_rn2(id_rn2), .id_flag_use2(id_flag_use2),
    .issue1(issue1_a), .issue2(issue2_a), .stall(stall_a), .pend_vec(pend_a)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cycles(stall_cycles_a), .split_cycles(split_cycles_a)
`endif
  );

  dual_issue_scoreboard #(.NREG(8), .AW(3), .ALU_LAT(2), .MEM_LAT(1)) dut_f (
    .clk(clk), .reset(reset), .flush(flush),
    .id_valid1(id_valid1), .id_we1(id_we1), .id_rd1(id_rd1), .id_rm1(id_rm1),
    .id_rn1(id_rn1), .id_use_rn1(id_use_rn1), .id_flag_we1(id_flag_we1),
    .id_valid2(id_valid2), .id_we2(id_we2), .id_rd2(id_rd2), .id_st2(id_st2),
    .id_rm2(id_rm2), .id_rn2(id_rn2), .id_flag_use2(id_flag_use2),
    .issue1(issue1_b), .issue2(issue2_b), .stall(stall_b), .pend_vec(pend_b)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cycles(stall_cycles_b), .split_cycles(split_cycles_b)
`endif
  );

  // driver tasks
  task automatic clr();
    flush = 0;
    id_valid1 = 0; id_we1 = 0; id_rd1 = 0; id_rm1 = 0; id_rn1 = 0;
    id_use_rn1 = 0; id_flag_we1 = 0;
    id_valid2 = 0; id_we2 = 0; id_rd2 = 0; id_st2 = 0; id_rm2 = 0;
    id_rn2 = 0; id_flag_use2 = 0;
  endtask

  task automatic slot1(input logic we, input logic [2:0] rd, input logic [2:0] rm,
                       input logic [2:0] rn, input logic urn, input logic fwe);
    id_valid1 = 1; id_we1 = we; id_rd1 = rd; id_rm1 = rm; id_rn1 = rn;
    id_use_rn1 = urn; id_flag_we1 = fwe;
  endtask

  task automatic slot2(input logic we, input logic [2:0] rd, input logic st,
                       input logic [2:0] rm, input logic [2:0] rn, input logic fu);
    id_valid2 = 1; id_we2 = we; id_rd2 = rd; id_st2 = st; id_rm2 = rm;
    id_rn2 = rn; id_flag_use2 = fu;
  endtask

  // Queue the expected response of the current cycle, then advance one cycle.
  task automatic tick(input logic sel, input logic [2:0] ist, input logic [7:0] pv);
    exp_q.push_back({sel, ist, pv});
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // scoreboard monitor: one queued expectation per presented cycle
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-2:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = e[W-1] ? {issue1_b, issue2_b, stall_b, pend_b}
                   : {issue1_a, issue2_a, stall_a, pend_a};
      n_cmp++;
      if (act !== e[W-2:0]) begin
        n_fail++;
        $display("FAIL vec%0d dut%0d: actual i1/i2/st=%b pend=%h required i1/i2/st=%b pend=%h",
                 cyc_no, e[W-1], act[10:8], act[7:0], e[10:8], e[7:0]);
      end
      cyc_no++;
    end
  end

  initial begin
    clr();
    reset = 1;
    step();
    // reset state of both instances
    tick(0, 3'b000, 8'h00);
    tick(1, 3'b000, 8'h00);
    reset = 0;

    // load-use: load r3, ADD r3 next cycle -> one bubble
    clr(); slot2(1, 3'd3, 0, 3'd1, 3'd1, 0);       tick(0, 3'b010, 8'h00);
    clr(); slot1(0, 3'd0, 3'd3, 3'd0, 1, 0);       tick(0, 3'b001, 8'h08);
    clr(); slot1(0, 3'd0, 3'd3, 3'd0, 1, 0);       tick(0, 3'b100, 8'h00);
    // intra-pair RAW split, then slot 2 alone
    clr(); slot1(1, 3'd2, 3'd1, 3'd0, 0, 0); slot2(0, 3'd0, 0, 3'd2, 3'd0, 0);
    tick(0, 3'b101, 8'h00);
    clr(); slot2(0, 3'd0, 0, 3'd2, 3'd0, 0);       tick(0, 3'b010, 8'h00);
`ifdef SCOREBOARD_STATS_EN
    check16("stall_cycles_after_scenarios", stall_cycles_a, 16'd2);
    check16("split_cycles_after_scenarios", split_cycles_a, 16'd1);
`endif
    // r0 immunity
    clr(); slot2(1, 3'd0, 0, 3'd0, 3'd0, 0);       tick(0, 3'b010, 8'h00);
    clr(); slot1(0, 3'd0, 3'd0, 3'd0, 1, 0);       tick(0, 3'b100, 8'h00);
    // store data source rd2 is a used source
    clr(); slot2(1, 3'd6, 0, 3'd1, 3'd1, 0);       tick(0, 3'b010, 8'h00);
    clr(); slot2(0, 3'd6, 1, 3'd1, 3'd1, 0);       tick(0, 3'b001, 8'h40);
    clr(); slot2(0, 3'd6, 1, 3'd1, 3'd1, 0);       tick(0, 3'b010, 8'h00);
    // WAW split, second write then pends for one cycle
    clr(); slot1(1, 3'd4, 3'd1, 3'd0, 0, 0); slot2(1, 3'd4, 0, 3'd1, 3'd1, 0);
    tick(0, 3'b101, 8'h00);
    clr(); slot2(1, 3'd4, 0, 3'd1, 3'd1, 0);       tick(0, 3'b010, 8'h00);
    clr();                                          tick(0, 3'b000, 8'h10);
    clr();                                          tick(0, 3'b000, 8'h00);
    // rn1 ignored when it is not a register operand
    clr(); slot2(1, 3'd5, 0, 3'd1, 3'd1, 0);       tick(0, 3'b010, 8'h00);
    clr(); slot1(0, 3'd0, 3'd1, 3'd5, 0, 0);       tick(0, 3'b100, 8'h20);
    // flush mid-stall releases and clears
    clr(); slot2(1, 3'd5, 0, 3'd1, 3'd1, 0);       tick(0, 3'b010, 8'h00);
    clr(); slot1(0, 3'd0, 3'd5, 3'd0, 1, 0); flush = 1;
    tick(0, 3'b000, 8'h20);
    clr(); slot1(0, 3'd0, 3'd5, 3'd0, 1, 0);       tick(0, 3'b100, 8'h00);

    // fresh start for the ALU_LAT=2 instance
    clr(); reset = 1;
    step();
    tick(1, 3'b000, 8'h00);
`ifdef SCOREBOARD_STATS_EN
    check16("stall_cycles_after_reset", stall_cycles_a, 16'd0);
    check16("split_cycles_after_reset", split_cycles_a, 16'd0);
`endif
    reset = 0;
    // flag: split, then branch stalls two cycles, then issues
    clr(); slot1(0, 3'd0, 3'd0, 3'd0, 0, 1); slot2(0, 3'd0, 0, 3'd0, 3'd0, 1);
    tick(1, 3'b101, 8'h00);
    clr(); slot2(0, 3'd0, 0, 3'd0, 3'd0, 1);       tick(1, 3'b001, 8'h00);
    clr(); slot2(0, 3'd0, 0, 3'd0, 3'd0, 1);       tick(1, 3'b001, 8'h00);
    clr(); slot2(0, 3'd0, 0, 3'd0, 3'd0, 1);       tick(1, 3'b010, 8'h00);
    // ALU result with ALU_LAT=2 blocks a consumer for two cycles
    clr(); slot1(1, 3'd7, 3'd1, 3'd0, 0, 0);       tick(1, 3'b100, 8'h00);
    clr(); slot1(0, 3'd0, 3'd7, 3'd0, 0, 0);       tick(1, 3'b001, 8'h80);
    clr(); slot1(0, 3'd0, 3'd7, 3'd0, 0, 0);       tick(1, 3'b001, 8'h80);
    clr(); slot1(0, 3'd0, 3'd7, 3'd0, 0, 0);       tick(1, 3'b100, 8'h00);
    clr();
    step();
    step();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual=%0d left required=0 left", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
